// File: rtl/dtw_pkg.sv
// Shared types and saturating arithmetic for the DTW accumulator and its cell datapath.
// No logic of its own; helpers are pure functions.
// Operands wider than 32 bits are not supported by the helpers.
package dtw_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  function automatic logic [31:0] cost_max(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Clamps at max instead of wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[31:0];
  endfunction

endpackage

// File: rtl/dtw_cell.sv
// One DTW cell: D = d + min(available neighbours), saturating at COST_MAX.
// Purely combinational, zero latency.
// No handshake; the caller decides when the result is used.
module dtw_cell
  import dtw_pkg::*;
#(
  parameter int DIST_W = 8,
  parameter int COST_W = 16
) (
  input  logic [DIST_W-1:0] d,
  input  logic [COST_W-1:0] up,
  input  logic [COST_W-1:0] left,
  input  logic [COST_W-1:0] diag,
  input  logic              first_row,
  input  logic              first_col,
  input  logic              force_max,
  output logic [COST_W-1:0] cost
);

  localparam logic [31:0]       CMAX32   = cost_max(COST_W);
  localparam logic [COST_W-1:0] COST_MAX = CMAX32[COST_W-1:0];

  logic [COST_W-1:0] base;
  logic [COST_W-1:0] mn;
  logic [31:0]       sum;

  always_comb begin
    mn = up;
    if (left < mn) mn = left;
    if (diag < mn) mn = diag;

    base = mn;
    if (first_row && first_col) base = '0;
    else if (first_row)         base = left;
    else if (first_col)         base = up;

    sum = sat_add(32'(d), 32'(base), CMAX32);

    cost = (sum > 32'(COST_MAX)) ? COST_MAX : sum[COST_W-1:0];
    if (force_max) cost = COST_MAX;
  end

endmodule

// File: rtl/dtw_accumulator.sv
// DTW cumulative-cost accumulator, one cell per cycle; DTW_BAND_EN enables a Sakoe-Chiba band.
// Latency: cost_valid rises the cycle after the last distance is accepted.
// Backpressure: dist_ready only in ACCUM; result held in DONE until cost_ready.
module dtw_accumulator
  import dtw_pkg::*;
#(
  parameter int DIST_W       = 8,
  parameter int COST_W       = 16,
  parameter int TEMPLATE_LEN = 32,
  parameter int ROW_W        = 8,
  parameter int BAND         = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ROW_W-1:0]  seq_len,
  input  logic              dist_valid,
  output logic              dist_ready,
  input  logic [DIST_W-1:0] dist_in,
  output logic              cost_valid,
  input  logic              cost_ready,
  output logic [COST_W-1:0] cost_out,
  output logic              busy
);

  localparam int             CW       = (TEMPLATE_LEN > 1) ? $clog2(TEMPLATE_LEN) : 1;
  localparam logic [CW-1:0]  LAST_COL = CW'(TEMPLATE_LEN - 1);

  state_t            state;
  logic [ROW_W-1:0]  row;
  logic [ROW_W-1:0]  len_m1;
  logic [CW-1:0]     col;
  logic [COST_W-1:0] left_q;
  logic [COST_W-1:0] diag_q;
  logic [COST_W-1:0] cell_d;
  logic [COST_W-1:0] rowbuf [TEMPLATE_LEN];
  logic              accept;
  logic              last_cell;
  logic              band_out;

  // A start in ACCUM wins over a coincident distance; that beat is discarded.
  assign accept    = dist_valid & dist_ready & ~start;
  assign last_cell = (row == len_m1) && (col == LAST_COL);

`ifdef DTW_BAND_EN
  assign band_out = (int'(row) > int'(col) + BAND) || (int'(col) > int'(row) + BAND);
`else
  assign band_out = 1'b0;
`endif

  dtw_cell #(
    .DIST_W (DIST_W),
    .COST_W (COST_W)
  ) u_cell (
    .d         (dist_in),
    .up        (rowbuf[col]),
    .left      (left_q),
    .diag      (diag_q),
    .first_row (row == '0),
    .first_col (col == '0),
    .force_max (band_out),
    .cost      (cell_d)
  );

  always_ff @(posedge clk) begin
    if (accept) rowbuf[col] <= cell_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dist_ready <= 1'b0;
      cost_valid <= 1'b0;
      cost_out   <= '0;
      busy       <= 1'b0;
      row        <= '0;
      col        <= '0;
      len_m1     <= '0;
      left_q     <= '0;
      diag_q     <= '0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (start) begin
            state      <= ACCUM;
            dist_ready <= 1'b1;
            busy       <= 1'b1;
            row        <= '0;
            col        <= '0;
            len_m1     <= (seq_len == '0) ? '0 : seq_len - ROW_W'(1);
          end else if (accept) begin
            left_q <= cell_d;
            // Old rowbuf[col] becomes the diagonal operand for col+1.
            diag_q <= rowbuf[col];
            if (col == LAST_COL) begin
              col <= '0;
              row <= row + ROW_W'(1);
            end else begin
              col <= col + CW'(1);
            end
            if (last_cell) begin
              state      <= DONE;
              dist_ready <= 1'b0;
              cost_valid <= 1'b1;
              cost_out   <= cell_d;
            end
          end
        end
        DONE: begin
          if (cost_ready) begin
            state      <= IDLE;
            cost_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          dist_ready <= 1'b0;
          cost_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtw_accumulator.sv
// Bench for dtw_accumulator (TEMPLATE_LEN=4, COST_W=8); expected costs come from a full-matrix DP model.
module tb_dtw_accumulator;

  localparam int DIST_W = 8;
  localparam int COST_W = 8;
  localparam int TL     = 4;
  localparam int ROW_W  = 8;
  localparam int BAND   = 0;
  localparam int CMAX   = (1 << COST_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ROW_W-1:0]  seq_len = '0;
  logic              dist_valid = 1'b0;
  logic              dist_ready;
  logic [DIST_W-1:0] dist_in = '0;
  logic              cost_valid;
  logic              cost_ready = 1'b0;
  logic [COST_W-1:0] cost_out;
  logic              busy;

  int tests = 0;
  int fails = 0;

  dtw_accumulator #(
    .DIST_W       (DIST_W),
    .COST_W       (COST_W),
    .TEMPLATE_LEN (TL),
    .ROW_W        (ROW_W),
    .BAND         (BAND)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .seq_len    (seq_len),
    .dist_valid (dist_valid),
    .dist_ready (dist_ready),
    .dist_in    (dist_in),
    .cost_valid (cost_valid),
    .cost_ready (cost_ready),
    .cost_out   (cost_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Whole cost matrix, straight from the recurrence.
  function automatic int model(input int len, input int dq[$]);
    int rows;
    int dm [256][TL];
    int best;
    int v;
    rows = (len == 0) ? 1 : len;
    for (int i = 0; i < rows; i++) begin
      for (int j = 0; j < TL; j++) begin
        if (i == 0 && j == 0) best = 0;
        else if (i == 0)      best = dm[0][j-1];
        else if (j == 0)      best = dm[i-1][0];
        else begin
          best = dm[i-1][j];
          if (dm[i][j-1] < best)   best = dm[i][j-1];
          if (dm[i-1][j-1] < best) best = dm[i-1][j-1];
        end
        v = dq[i*TL+j] + best;
        dm[i][j] = (v > CMAX) ? CMAX : v;
`ifdef DTW_BAND_EN
        if (i - j > BAND || j - i > BAND) dm[i][j] = CMAX;
`endif
      end
    end
    return dm[rows-1][TL-1];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len);
    logic [31:0] l;
    l = 32'(len);
    start = 1'b1;
    seq_len = l[ROW_W-1:0];
    dist_valid = 1'b0;
    tick();
    start = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_rdy", 32'(dist_ready), 1);
  endtask

  task automatic send(input int dq[$], input int n, input bit gaps);
    logic [31:0] v;
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        dist_valid = 1'b0;
        tick();
      end
      v = 32'(dq[k]);
      dist_valid = 1'b1;
      dist_in = v[DIST_W-1:0];
      check("stream_rdy", 32'(dist_ready), 1);
      if (k == n - 1) check("early_cost_valid", 32'(cost_valid), 0);
      tick();
    end
    dist_valid = 1'b0;
  endtask

  task automatic run_job(input int len, input int dq[$], input int exp, input int hold,
                         input bit gaps);
    int rows;
    logic [COST_W-1:0] held;
    rows = (len == 0) ? 1 : len;
    do_start(len);
    send(dq, rows * TL, gaps);
    check("done_valid", 32'(cost_valid), 1);
    check("done_cost", 32'(cost_out), 32'(exp));
    check("done_rdy", 32'(dist_ready), 0);
    check("done_busy", 32'(busy), 1);
    held = cost_out;
    for (int h = 0; h < hold; h++) begin
      cost_ready = 1'b0;
      dist_valid = 1'b1;
      dist_in = 8'($urandom_range(0, 255));
      start = 1'b1;
      seq_len = 8'($urandom_range(0, 7));
      tick();
      check("hold_valid", 32'(cost_valid), 1);
      check("hold_cost", 32'(cost_out), 32'(held));
      check("hold_rdy", 32'(dist_ready), 0);
    end
    start = 1'b0;
    dist_valid = 1'b0;
    cost_ready = 1'b1;
    tick();
    cost_ready = 1'b0;
    check("idle_valid", 32'(cost_valid), 0);
    check("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    int q[$];
    int len;
    int hi;
    int exp;

    // Reset state
    #2;
    check("rst_rdy", 32'(dist_ready), 0);
    check("rst_valid", 32'(cost_valid), 0);
    check("rst_cost", 32'(cost_out), 0);
    check("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // dist_valid in IDLE is ignored
    dist_valid = 1'b1;
    dist_in = 8'd7;
    tick();
    tick();
    check("idle_ignore_rdy", 32'(dist_ready), 0);
    check("idle_ignore_busy", 32'(busy), 0);
    dist_valid = 1'b0;

    // All ones, 4x4
    q = {};
    for (int k = 0; k < 16; k++) q.push_back(1);
    run_job(4, q, 4, 0, 1'b0);

    // Single row, seq_len 1 and 0
    q = {1, 2, 3, 4};
`ifdef DTW_BAND_EN
    exp = CMAX;
`else
    exp = 10;
`endif
    run_job(1, q, exp, 0, 1'b0);
    run_job(0, q, exp, 0, 1'b1);

    // Saturation
    q = {};
    for (int k = 0; k < 16; k++) q.push_back(255);
    run_job(4, q, CMAX, 0, 1'b0);

    // Result held under backpressure with start/dist_valid noise
    q = {};
    for (int k = 0; k < 16; k++) q.push_back(1);
    run_job(4, q, 4, 10, 1'b0);

    // Async reset after 5 distances
    do_start(4);
    send(q, 5, 1'b0);
    rst_n = 1'b0;
    #2;
    check("midrst_valid", 32'(cost_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_rdy", 32'(dist_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("postrst_valid", 32'(cost_valid), 0);
    run_job(4, q, 4, 0, 1'b0);

    // Restart by start mid-ACCUM
    q = {};
    for (int k = 0; k < 7; k++) q.push_back(int'($urandom_range(20, 200)));
    do_start(4);
    send(q, 7, 1'b0);
    check("abort_valid", 32'(cost_valid), 0);
    q = {};
    for (int k = 0; k < 16; k++) q.push_back(1);
    run_job(4, q, 4, 0, 1'b0);

    // Diagonal-heavy matrix
    q = {};
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < TL; j++) q.push_back((i == j) ? 9 : 0);
`ifdef DTW_BAND_EN
    exp = 36;
`else
    exp = 18;
`endif
    run_job(4, q, exp, 0, 1'b0);

    // Randomized jobs against the model
    for (int r = 0; r < 10; r++) begin
      len = int'($urandom_range(0, 7));
      hi = ($urandom_range(0, 3) == 0) ? 255 : 20;
      q = {};
      for (int k = 0; k < ((len == 0) ? 1 : len) * TL; k++)
        q.push_back(int'($urandom_range(0, hi)));
      run_job(len, q, model(len, q), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
